// File: rtl/float_sub_16bit_pipe_if.sv
// Handshake/data bundle for float_sub_16bit_pipe: operand pair in, difference and flags out.
// master drives operands and out_ready; slave is the subtractor.
interface float_sub_16bit_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float1;
    logic [15:0] float2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        invalid;
    logic        overflow;

    modport master (
        output in_valid, float1, float2, out_ready,
        input  in_ready, out_valid, diff, invalid, overflow
    );

    modport slave (
        input  in_valid, float1, float2, out_ready,
        output in_ready, out_valid, diff, invalid, overflow
    );
endinterface

// File: rtl/float_sub_16bit_pipe.sv
// Three-stage IEEE-754 half-precision subtractor, diff = float1 - float2, valid/ready on both sides.
// Define FPU_SUB_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
package fpu_types_pkg;
    localparam int unsigned HALF_FLOAT_W    = 16;
    localparam int unsigned HALF_FRACTION_W = 10;
    localparam logic [15:0] HALF_NAN        = 16'h7E00;
    localparam logic [15:0] HALF_INF        = 16'h7C00;
    localparam logic [15:0] HALF_INFN       = 16'hFC00;
endpackage

module float_sub_16bit_pipe
    import fpu_types_pkg::*;
#(
    parameter bit SAT_OVERFLOW = 1'b0
) (
    input logic CLK,
    input logic RST,
    float_sub_16bit_pipe_if.slave io
);
    logic s1_adv, s2_adv, s3_adv, in_fire;

    logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic [4:0]  s1_exp_q, s1_exp_d;
    logic [13:0] s1_siga_q, s1_siga_d, s1_sigb_q, s1_sigb_d;
    logic        s1_spec_q, s1_spec_d, s1_inv_q, s1_inv_d, s1_negz_q, s1_negz_d;
    logic [HALF_FLOAT_W-1:0] s1_sval_q, s1_sval_d;

    logic        s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic [4:0]  s2_exp_q, s2_exp_d;
    logic [14:0] s2_sum_q, s2_sum_d;
    logic        s2_spec_q, s2_spec_d, s2_inv_q, s2_inv_d, s2_negz_q, s2_negz_d;
    logic [HALF_FLOAT_W-1:0] s2_sval_q, s2_sval_d;

    logic        s3_valid_q, s3_valid_d, s3_inv_q, s3_inv_d, s3_ovf_q, s3_ovf_d;
    logic [HALF_FLOAT_W-1:0] s3_diff_q, s3_diff_d;

    // S1 working signals
    logic [14:0] mag1, mag2, mag_a, mag_b;
    logic        sign2_eff, swap, sign_a, sign_b;
    logic [4:0]  exp_a, exp_b, exp_dist;
    logic [3:0]  sh_b;
    logic [10:0] sig_a, sig_b;
    logic [24:0] wide_b;
    logic        nan1, nan2, inf1, inf2, zero1, zero2;

    // S3 working signals
    logic [3:0]  lzc;
    logic [4:0]  lim, shamt;
    logic [6:0]  exp_n, efield;
    logic [10:0] mant;
    logic        rnd, ovf;
    logic [16:0] packed_r;
`ifdef FPU_SUB_RNE_EN
    logic [13:0] norm;
`endif

    always_comb begin
        s3_adv      = s3_valid_q & io.out_ready;
        s2_adv      = s2_valid_q & (!s3_valid_q | s3_adv);
        s1_adv      = s1_valid_q & (!s2_valid_q | s2_adv);
        io.in_ready = !s1_valid_q | s1_adv;
        in_fire     = io.in_valid & io.in_ready;
        s1_valid_d  = in_fire | (s1_valid_q & !s1_adv);
        s2_valid_d  = s1_adv  | (s2_valid_q & !s2_adv);
        s3_valid_d  = s2_adv  | (s3_valid_q & !s3_adv);
        io.out_valid = s3_valid_q;
        io.diff      = s3_diff_q;
        io.invalid   = s3_inv_q;
        io.overflow  = s3_ovf_q;
    end

    // S1: unpack, order by magnitude, align B with guard/round/sticky
    always_comb begin
        mag1      = io.float1[14:0];
        mag2      = io.float2[14:0];
        sign2_eff = ~io.float2[15];
        swap      = mag2 > mag1;
        mag_a     = swap ? mag2 : mag1;
        mag_b     = swap ? mag1 : mag2;
        sign_a    = swap ? sign2_eff : io.float1[15];
        sign_b    = swap ? io.float1[15] : sign2_eff;
        exp_a     = (mag_a[14:10] == 5'd0) ? 5'd1 : mag_a[14:10];
        exp_b     = (mag_b[14:10] == 5'd0) ? 5'd1 : mag_b[14:10];
        sig_a     = {|mag_a[14:10], mag_a[HALF_FRACTION_W-1:0]};
        sig_b     = {|mag_b[14:10], mag_b[HALF_FRACTION_W-1:0]};
        exp_dist  = exp_a - exp_b;
        // distances past 14 only feed sticky, so clamping keeps every bit of B inside wide_b
        sh_b      = (exp_dist > 5'd14) ? 4'd14 : exp_dist[3:0];
        wide_b    = {sig_b, 14'b0} >> sh_b;

        nan1  = (&io.float1[14:10]) &  (|io.float1[9:0]);
        nan2  = (&io.float2[14:10]) &  (|io.float2[9:0]);
        inf1  = (&io.float1[14:10]) & ~(|io.float1[9:0]);
        inf2  = (&io.float2[14:10]) & ~(|io.float2[9:0]);
        zero1 = ~(|io.float1[14:0]);
        zero2 = ~(|io.float2[14:0]);

        s1_sign_d = s1_sign_q;
        s1_sub_d  = s1_sub_q;
        s1_exp_d  = s1_exp_q;
        s1_siga_d = s1_siga_q;
        s1_sigb_d = s1_sigb_q;
        s1_spec_d = s1_spec_q;
        s1_inv_d  = s1_inv_q;
        s1_sval_d = s1_sval_q;
        s1_negz_d = s1_negz_q;
        if (in_fire) begin
            s1_sign_d = sign_a;
            s1_sub_d  = sign_a ^ sign_b;
            s1_exp_d  = exp_a;
            s1_siga_d = {sig_a, 3'b000};
            s1_sigb_d = {wide_b[24:12], |wide_b[11:0]};
            s1_negz_d = zero1 & zero2 & io.float1[15] & ~io.float2[15];
            s1_spec_d = 1'b1;
            s1_inv_d  = 1'b0;
            s1_sval_d = '0;
            if (nan1 | nan2 | (inf1 & inf2 & (io.float1[15] == io.float2[15]))) begin
                s1_inv_d  = 1'b1;
                s1_sval_d = HALF_NAN;
            end else if (inf1) begin
                s1_sval_d = io.float1[15] ? HALF_INFN : HALF_INF;
            end else if (inf2) begin
                s1_sval_d = io.float2[15] ? HALF_INF : HALF_INFN;
            end else begin
                s1_spec_d = 1'b0;
            end
        end
    end

    // S2: magnitude add or subtract; A >= B so the difference is never negative
    always_comb begin
        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_sum_d  = s2_sum_q;
        s2_spec_d = s2_spec_q;
        s2_inv_d  = s2_inv_q;
        s2_sval_d = s2_sval_q;
        s2_negz_d = s2_negz_q;
        if (s1_adv) begin
            s2_sign_d = s1_sign_q;
            s2_exp_d  = s1_exp_q;
            s2_sum_d  = s1_sub_q ? ({1'b0, s1_siga_q} - {1'b0, s1_sigb_q})
                                 : ({1'b0, s1_siga_q} + {1'b0, s1_sigb_q});
            s2_spec_d = s1_spec_q;
            s2_inv_d  = s1_inv_q;
            s2_sval_d = s1_sval_q;
            s2_negz_d = s1_negz_q;
        end
    end

    // S3: normalize, round, pack, resolve specials
    always_comb begin
        lzc = 4'd14;
        for (int unsigned i = 0; i < 14; i++) begin
            if (s2_sum_q[i]) lzc = 4'(13 - i);
        end
        lim   = s2_exp_q - 5'd1;
        shamt = ({1'b0, lzc} < lim) ? {1'b0, lzc} : lim;
        exp_n = s2_sum_q[14] ? ({2'b0, s2_exp_q} + 7'd1) : ({2'b0, s2_exp_q} - {2'b0, shamt});
`ifdef FPU_SUB_RNE_EN
        norm  = s2_sum_q[14] ? {s2_sum_q[14:2], |s2_sum_q[1:0]} : (s2_sum_q[13:0] << shamt);
        mant  = norm[13:3];
        rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        mant  = s2_sum_q[14] ? s2_sum_q[14:4] : 11'((s2_sum_q[13:0] << shamt) >> 3);
        rnd   = 1'b0;
`endif
        // a rounding carry ripples from the fraction into the exponent field, renormalizing for free
        efield   = mant[10] ? exp_n : 7'd0;
        packed_r = {efield, mant[9:0]} + {16'b0, rnd};
        ovf      = packed_r[16:10] >= 7'd31;

        s3_diff_d = s3_diff_q;
        s3_inv_d  = s3_inv_q;
        s3_ovf_d  = s3_ovf_q;
        if (s2_adv) begin
            s3_inv_d = 1'b0;
            s3_ovf_d = 1'b0;
            if (s2_spec_q) begin
                s3_diff_d = s2_sval_q;
                s3_inv_d  = s2_inv_q;
            end else if (s2_sum_q == 15'd0) begin
                s3_diff_d = s2_negz_q ? 16'h8000 : 16'h0000;
            end else if (ovf) begin
                s3_ovf_d  = 1'b1;
                if (SAT_OVERFLOW) s3_diff_d = {s2_sign_q, 15'h7BFF};
                else              s3_diff_d = s2_sign_q ? HALF_INFN : HALF_INF;
            end else begin
                s3_diff_d = {s2_sign_q, packed_r[14:0]};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0; s2_valid_q <= 1'b0; s3_valid_q <= 1'b0;
            s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_exp_q <= '0;
            s1_siga_q <= '0; s1_sigb_q <= '0; s1_spec_q <= 1'b0;
            s1_inv_q <= 1'b0; s1_sval_q <= '0; s1_negz_q <= 1'b0;
            s2_sign_q <= 1'b0; s2_exp_q <= '0; s2_sum_q <= '0;
            s2_spec_q <= 1'b0; s2_inv_q <= 1'b0; s2_sval_q <= '0; s2_negz_q <= 1'b0;
            s3_diff_q <= '0; s3_inv_q <= 1'b0; s3_ovf_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d; s2_valid_q <= s2_valid_d; s3_valid_q <= s3_valid_d;
            s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d; s1_exp_q <= s1_exp_d;
            s1_siga_q <= s1_siga_d; s1_sigb_q <= s1_sigb_d; s1_spec_q <= s1_spec_d;
            s1_inv_q <= s1_inv_d; s1_sval_q <= s1_sval_d; s1_negz_q <= s1_negz_d;
            s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d; s2_sum_q <= s2_sum_d;
            s2_spec_q <= s2_spec_d; s2_inv_q <= s2_inv_d; s2_sval_q <= s2_sval_d; s2_negz_q <= s2_negz_d;
            s3_diff_q <= s3_diff_d; s3_inv_q <= s3_inv_d; s3_ovf_q <= s3_ovf_d;
        end
    end
endmodule
